// File: rtl/gpu_bg_pkg.sv
// Shared types and constants for the background block transfer engine.
package gpu_bg_pkg;

  localparam int unsigned BG_BEATS   = 8;
  localparam int unsigned BG_BEAT_W  = 32;
  localparam int unsigned BG_BLOCK_W = 256;
  localparam int unsigned BG_MASK_W  = 16;
  localparam int unsigned BG_ADR_W   = 15;

  // Pair code presented on i_saveBGBlock.
  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_FIRST = 2'b01;
  localparam logic [1:0] CODE_NEXT  = 2'b10;
  localparam logic [1:0] CODE_FLUSH = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StSaveCmd,
    StSaveBeat,
    StLoadCmd,
    StLoadBeat,
    StImport,
    StDone,
    StWaitClr
  } bg_state_e;

  function automatic logic beat_is_last(input logic [2:0] idx);
    return idx == 3'(BG_BEATS - 1);
  endfunction

endpackage

// File: rtl/bg_beat_shifter.sv
// Holds the latched save block/mask and serialises it into 32-bit beats;
// assembles incoming 32-bit read beats into the imported 256-bit block.
module bg_beat_shifter
  import gpu_bg_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  latch_i,
  input  logic [BG_BLOCK_W-1:0] block_i,
  input  logic [BG_MASK_W-1:0]  mask_i,
  input  logic [2:0]            beat_idx_i,
  input  logic                  rd_en_i,
  input  logic [BG_BEAT_W-1:0]  rd_data_i,
  output logic [BG_BEAT_W-1:0]  wr_data_o,
  output logic [1:0]            wr_mask_o,
  output logic [BG_BLOCK_W-1:0] rd_block_o
);

  logic [BG_BLOCK_W-1:0] save_block_q;
  logic [BG_MASK_W-1:0]  save_mask_q;
  logic [BG_BLOCK_W-1:0] load_block_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      save_block_q <= '0;
      save_mask_q  <= '0;
      load_block_q <= '0;
    end else begin
      if (latch_i) begin
        save_block_q <= block_i;
        save_mask_q  <= mask_i;
      end
      if (rd_en_i) begin
        load_block_q[{beat_idx_i, 5'b0} +: BG_BEAT_W] <= rd_data_i;
      end
    end
  end

  // Two mask bits per beat: one per 16-bit pixel.
  assign wr_data_o  = save_block_q[{beat_idx_i, 5'b0} +: BG_BEAT_W];
  assign wr_mask_o  = save_mask_q[{beat_idx_i, 1'b0} +: 2];
  assign rd_block_o = load_block_q;

endmodule

// File: rtl/bg_block_transfer.sv
// Background block save/load engine: writes the exported block to memory and/or
// reads the next block back. Define GPU_BG_SKIP_EMPTY_SAVE_EN to skip all-masked saves.
module bg_block_transfer
  import gpu_bg_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_nrst,
  input  logic [1:0]            i_saveBGBlock,
  input  logic [BG_ADR_W-1:0]   i_loadAdr,
  input  logic [BG_ADR_W-1:0]   i_saveAdr,
  input  logic [BG_BLOCK_W-1:0] i_exportedBGBlock,
  input  logic [BG_MASK_W-1:0]  i_exportedMSKBGBlock,
  output logic                  o_pausePipeline,
  output logic                  o_resetPipelinePixelStateSpike,
  output logic                  o_resetPixelMask,
  output logic                  o_importBGBlockSingleClock,
  output logic [BG_BLOCK_W-1:0] o_importedBGBlock,
  output logic                  o_memCmdValid,
  input  logic                  i_memCmdReady,
  output logic                  o_memCmdWrite,
  output logic [BG_ADR_W-1:0]   o_memCmdAdr,
  output logic                  o_memWrValid,
  input  logic                  i_memWrReady,
  output logic [BG_BEAT_W-1:0]  o_memWrData,
  output logic [1:0]            o_memWrMask,
  input  logic                  i_memRdValid,
  input  logic [BG_BEAT_W-1:0]  i_memRdData
);

  bg_state_e             state_q, state_d;
  logic [1:0]            code_q, code_d;
  logic [BG_ADR_W-1:0]   load_adr_q, load_adr_d;
  logic [BG_ADR_W-1:0]   save_adr_q, save_adr_d;
  logic [2:0]            beat_q, beat_d;
  logic                  cmd_valid_q, cmd_write_q, wr_valid_q, import_q, done_q;
  logic [BG_ADR_W-1:0]   cmd_adr_q;
  logic                  start, skip_save, rd_en;
  logic [BG_BEAT_W-1:0]  sh_wr_data;
  logic [1:0]            sh_wr_mask;

  assign start = (state_q == StIdle) && (i_saveBGBlock != CODE_NONE);
  assign rd_en = (state_q == StLoadBeat) && i_memRdValid;

`ifdef GPU_BG_SKIP_EMPTY_SAVE_EN
  assign skip_save = (i_exportedMSKBGBlock == '0);
`else
  assign skip_save = 1'b0;
`endif

  always_comb begin
    code_d     = code_q;
    load_adr_d = load_adr_q;
    save_adr_d = save_adr_q;
    if (start) begin
      code_d     = i_saveBGBlock;
      load_adr_d = i_loadAdr;
      save_adr_d = i_saveAdr;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (i_saveBGBlock == CODE_FIRST) begin
            state_d = StLoadCmd;
          end else if (skip_save) begin
            state_d = (i_saveBGBlock == CODE_NEXT) ? StLoadCmd : StDone;
          end else begin
            state_d = StSaveCmd;
          end
        end
      end
      StSaveCmd: begin
        if (cmd_valid_q && i_memCmdReady) begin
          state_d = StSaveBeat;
          beat_d  = '0;
        end
      end
      StSaveBeat: begin
        if (wr_valid_q && i_memWrReady) begin
          if (beat_is_last(beat_q)) begin
            state_d = (code_q == CODE_NEXT) ? StLoadCmd : StDone;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      StLoadCmd: begin
        if (cmd_valid_q && i_memCmdReady) begin
          state_d = StLoadBeat;
          beat_d  = '0;
        end
      end
      StLoadBeat: begin
        if (i_memRdValid) begin
          if (beat_is_last(beat_q)) begin
            state_d = StImport;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      StImport:  state_d = StDone;
      StDone:    state_d = StWaitClr;
      StWaitClr: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are registered off the next state so they line up with state_q.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= StIdle;
      code_q      <= CODE_NONE;
      load_adr_q  <= '0;
      save_adr_q  <= '0;
      beat_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_adr_q   <= '0;
      wr_valid_q  <= 1'b0;
      import_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      load_adr_q  <= load_adr_d;
      save_adr_q  <= save_adr_d;
      beat_q      <= beat_d;
      cmd_valid_q <= (state_d == StSaveCmd) || (state_d == StLoadCmd);
      cmd_write_q <= (state_d == StSaveCmd);
      cmd_adr_q   <= (state_d == StSaveCmd) ? save_adr_d :
                     (state_d == StLoadCmd) ? load_adr_d : '0;
      wr_valid_q  <= (state_d == StSaveBeat);
      import_q    <= (state_d == StImport);
      done_q      <= (state_d == StDone);
    end
  end

  bg_beat_shifter u_shifter (
    .clk_i      (clk),
    .rst_ni     (i_nrst),
    .latch_i    (start),
    .block_i    (i_exportedBGBlock),
    .mask_i     (i_exportedMSKBGBlock),
    .beat_idx_i (beat_q),
    .rd_en_i    (rd_en),
    .rd_data_i  (i_memRdData),
    .wr_data_o  (sh_wr_data),
    .wr_mask_o  (sh_wr_mask),
    .rd_block_o (o_importedBGBlock)
  );

  assign o_pausePipeline                = (state_q != StIdle) || (i_saveBGBlock != CODE_NONE);
  assign o_resetPipelinePixelStateSpike = done_q;
  assign o_resetPixelMask               = done_q;
  assign o_importBGBlockSingleClock     = import_q;
  assign o_memCmdValid                  = cmd_valid_q;
  assign o_memCmdWrite                  = cmd_write_q;
  assign o_memCmdAdr                    = cmd_adr_q;
  assign o_memWrValid                   = wr_valid_q;
  assign o_memWrData                    = wr_valid_q ? sh_wr_data : '0;
  assign o_memWrMask                    = wr_valid_q ? sh_wr_mask : '0;

endmodule

// File: doc/bg_block_transfer.md
BG_BLOCK_TRANSFER -- requirements
Module: bg_block_transfer

Interface
REQ-001 SHALL have: clk  in  1  single clock, all logic on rising edge; one clock, reset asynchronous, active-low.
REQ-002 SHALL have: i_nrst  in  1  asynchronous active-low reset.
REQ-003 SHALL have: i_saveBGBlock  in  2  pair code: 00 none, 01 first block, 10 next block, 11 flush.
REQ-004 SHALL have: i_loadAdr / i_saveAdr  in  15 each  block address to load / to save.
REQ-005 SHALL have: i_exportedBGBlock  in  256 and i_exportedMSKBGBlock  in  16  block to save and its per-pixel write mask.
REQ-006 SHALL have: o_pausePipeline, o_resetPipelinePixelStateSpike, o_resetPixelMask, o_importBGBlockSingleClock  out  1 each.
REQ-007 SHALL have: o_importedBGBlock  out  256  assembled loaded block.
REQ-008 SHALL have command port: o_memCmdValid out 1, i_memCmdReady in 1, o_memCmdWrite out 1, o_memCmdAdr out 15.
REQ-009 SHALL have write-beat port: o_memWrValid out 1, i_memWrReady in 1, o_memWrData out 32, o_memWrMask out 2 (one bit per pixel).
REQ-010 SHALL have read-beat port: i_memRdValid in 1, i_memRdData in 32; no backpressure.

Function
REQ-011 SHALL use states IDLE, SAVE_CMD, SAVE_BEAT, LOAD_CMD, LOAD_BEAT, IMPORT, DONE, WAIT_CLR.
REQ-012 In IDLE with nonzero code, SHALL latch code, both addresses, block and mask in the same cycle.
REQ-013 Transitions from IDLE: code 01 -> LOAD_CMD; 10 -> SAVE_CMD; 11 -> SAVE_CMD.
REQ-014 SAVE_CMD SHALL assert o_memCmdValid, o_memCmdWrite=1, o_memCmdAdr=latched saveAdr; all held stable until i_memCmdReady, then -> SAVE_BEAT.
REQ-015 SAVE_BEAT SHALL send 8 beats, beat k = block[32k+31:32k], mask = msk[2k+1:2k], advancing only on o_memWrValid & i_memWrReady.
REQ-016 After beat 7: code 10 -> LOAD_CMD; code 11 -> DONE.
REQ-017 LOAD_CMD SHALL behave as SAVE_CMD with o_memCmdWrite=0, adr=latched loadAdr, then -> LOAD_BEAT.
REQ-018 LOAD_BEAT SHALL store read beat k into o_importedBGBlock[32k+31:32k], k = 0..7 in arrival order; after beat 7 -> IMPORT.
REQ-019 i_memRdValid outside LOAD_BEAT SHALL be ignored.
REQ-020 IMPORT SHALL pulse o_importBGBlockSingleClock for exactly one cycle with o_importedBGBlock complete, then -> DONE.
REQ-021 DONE SHALL pulse o_resetPipelinePixelStateSpike and o_resetPixelMask for one cycle, then -> WAIT_CLR.
REQ-022 WAIT_CLR SHALL last one cycle, ignore the input code, then -> IDLE.
REQ-023 o_pausePipeline SHALL equal (state != IDLE) | (state == IDLE & code != 00), combinationally.
REQ-024 Code changes after latch SHALL NOT affect the running operation.
REQ-025 Beat counter SHALL be 3 bits, cleared on entry to SAVE_BEAT and LOAD_BEAT; no wrap beyond 7.

Reset
REQ-026 On i_nrst low: state IDLE, all outputs 0, o_importedBGBlock 0, counters 0, regardless of operation in progress.
REQ-027 Reset mid-transfer SHALL abandon it: no import pulse and no reset pulses.

Configuration
REQ-028 Macro GPU_BG_SKIP_EMPTY_SAVE_EN defined: when latched mask == 0, the save phase is skipped (code 10 -> LOAD_CMD, code 11 -> DONE directly from IDLE).
REQ-029 Macro undefined: save always performed, including all-zero mask.

Structure
REQ-030 Shared package gpu_bg_pkg SHALL hold the state enum, pair-code constants (NONE/FIRST/NEXT/FLUSH) and BG_BEATS=8.
REQ-031 Serialization/deserialization of 256<->32 SHALL live in sub-module bg_beat_shifter; the FSM stays in bg_block_transfer.

Verification
REQ-032 Code 01, loadAdr=0x0123, ready always 1, read beats 0x11111111..0x88888888 -> one read cmd adr 0x0123, import pulse with block = beats in order, reset pulses the next cycle, pause low after WAIT_CLR.
REQ-033 Code 10, saveAdr=0x0040, mask=0xFFFF, loadAdr=0x0041 -> write cmd 0x0040, 8 beats with mask 11, then read cmd 0x0041, import pulse.
REQ-034 Code 11, mask=0x0003, i_memWrReady toggling 1/0 -> 8 beats; beat 0 mask 11, others 00; data stable while not ready; no read cmd; no import pulse.
REQ-035 Code 11, mask=0x0000 -> with GPU_BG_SKIP_EMPTY_SAVE_EN: no cmd, DONE pulses within 2 cycles; without the macro: full 8-beat save.
REQ-036 i_nrst low during LOAD_BEAT beat 4 -> all outputs 0, no import pulse; a subsequent code 01 completes normally.
REQ-037 Code held at 10 through WAIT_CLR, and stray i_memRdValid in IDLE -> exactly one operation; stray data does not alter o_importedBGBlock.
